// File: rtl/button_debounce.sv
// button_debounce: synchronise, debounce and strobe a raw push-button pin.
// Optional long-hold strobe is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit BUT_ACTIVE_LOW  = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BUT,
    output logic       BUT_PRESSED,
    output logic       PRESS_PULSE,
    output logic       RELEASE_PULSE,
    output logic [7:0] PRESS_COUNT,
    output logic       LONG_PRESS
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
        $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, p;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pressed_q, pressed_d, press_q, press_d, release_q, release_d;
    logic [7:0]    count_q, count_d;

    assign p = BUT_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // Sync flops preset to the released pin level so reset release never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q   <= BUT_ACTIVE_LOW;
            sync2_q   <= BUT_ACTIVE_LOW;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync1_q   <= BUT;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            RELEASED: if (p) begin
                state_d = PRESS_PEND;
                cnt_d   = '0;
            end
            PRESS_PEND: if (!p) state_d = RELEASED;
            else if (cnt_q == CNT_MAX) begin
                state_d   = PRESSED;
                pressed_d = 1'b1;
                press_d   = 1'b1;
                count_d   = count_q + 8'd1;
            end else cnt_d = cnt_q + 1'b1;
            PRESSED: if (!p) begin
                state_d = RELEASE_PEND;
                cnt_d   = '0;
            end
            RELEASE_PEND: if (p) state_d = PRESSED;
            else if (cnt_q == CNT_MAX) begin
                state_d   = RELEASED;
                pressed_d = 1'b0;
                release_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = RELEASED;
        endcase
    end

    assign BUT_PRESSED   = pressed_q;
    assign PRESS_PULSE   = press_q;
    assign RELEASE_PULSE = release_q;
    assign PRESS_COUNT   = count_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d, long_q, long_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    // Hold time spans release bounces; only an accepted press or release restarts it.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (press_d || state_d == RELEASED) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == PRESSED || state_q == RELEASE_PEND) begin
            if (hold_q == HOLD_MAX) begin
                long_d  = ~fired_q;
                fired_d = 1'b1;
            end else hold_d = hold_q + 1'b1;
        end
    end

    assign LONG_PRESS = long_q;
`else
    assign LONG_PRESS = 1'b0;
`endif
endmodule
